aes128_block_ctrl: RTL and testbench

Block-level sequencer in front of the iterative AES-128 core (aes128_fsm). It accepts 128-bit blocks over a valid/ready stream and drives the core's start/op/key/data pins. It applies ECB or CBC chaining (encrypt and decrypt) and returns results over a backpressured output stream. It owns the IV/chaining register and a processed-block counter.

---
 rtl/aes128_block_ctrl.sv | 147 ++++++++++++++
 tb/tb_aes128_block_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_block_ctrl.sv
// Block sequencer in front of the iterative AES-128 core: ECB/CBC chaining,
// valid/ready in and out, one block in flight, chain register and block counter.

module aes128_lane_xor #(
    parameter int VEC_W = 32
) (
    input  logic [VEC_W-1:0] a,
    input  logic [VEC_W-1:0] b,
    input  logic             en,
    output logic [VEC_W-1:0] y
);
    assign y = en ? (a ^ b) : a;
endmodule

module aes128_block_ctrl #(
    parameter int CNT_W     = 16,
    parameter int NUM_LANES = 4,
    parameter int VEC_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_cbc_i,
    input  logic             cfg_decrypt_i,
    input  logic [127:0]     key_i,
    input  logic [127:0]     iv_i,
    input  logic             iv_load_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [127:0]     in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [127:0]     out_data_o,
    output logic             core_start_o,
    output logic [1:0]       core_op_o,
    output logic [127:0]     core_key_o,
    output logic [127:0]     core_data_o,
    input  logic [127:0]     core_result_i,
    input  logic             core_valid_i,
    input  logic             core_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] block_count_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CORE, OUTPUT} state_t;

    typedef struct packed {
        logic cbc;
        logic decrypt;
    } blk_cfg_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t   state_q, state_d;
    blk_cfg_t cfg_q;

    logic [NUM_LANES-1:0][VEC_W-1:0] key_q, blk_q, core_data_q, chain_q, out_q;
    logic [NUM_LANES-1:0][VEC_W-1:0] pre_xor, post_xor;
    logic                            out_valid_q;
    logic [CNT_W-1:0]                cnt_q;

    logic accept, core_done, out_done, pre_en, post_en;

    assign accept    = in_valid_i && in_ready_o;
    assign core_done = (state_q == WAIT_CORE) && core_valid_i && core_ready_i;
    assign out_done  = (state_q == OUTPUT) && out_ready_i;

    // Pre-whitening uses the live config (it happens at accept); post-whitening
    // uses the latched config of the block in flight.
    assign pre_en  = cfg_cbc_i && !cfg_decrypt_i;
    assign post_en = cfg_q.cbc && cfg_q.decrypt;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        aes128_lane_xor #(.VEC_W(VEC_W)) u_pre (
            .a  (in_data_i[l*VEC_W +: VEC_W]),
            .b  (chain_q[l]),
            .en (pre_en),
            .y  (pre_xor[l])
        );
        aes128_lane_xor #(.VEC_W(VEC_W)) u_post (
            .a  (core_result_i[l*VEC_W +: VEC_W]),
            .b  (chain_q[l]),
            .en (post_en),
            .y  (post_xor[l])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept)    state_d = ISSUE;
            ISSUE:                    state_d = WAIT_CORE;
            WAIT_CORE: if (core_done) state_d = OUTPUT;
            OUTPUT:    if (out_done)  state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o   = (state_q == IDLE) && !iv_load_i && core_ready_i;
        core_start_o = (state_q == ISSUE);
        busy_o       = (state_q != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q       <= '0;
            key_q       <= '0;
            blk_q       <= '0;
            core_data_q <= '0;
            chain_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if ((state_q == IDLE) && iv_load_i) begin
                chain_q <= iv_i;
                cnt_q   <= '0;
            end
            if (accept) begin
                cfg_q       <= '{cbc: cfg_cbc_i, decrypt: cfg_decrypt_i};
                key_q       <= key_i;
                blk_q       <= in_data_i;
                core_data_q <= pre_xor;
            end
            if (core_done) begin
                out_q       <= post_xor;
                out_valid_q <= 1'b1;
                cnt_q       <= cnt_q + CNT_ONE;
                // CBC decrypt chains on the ciphertext that went in, encrypt on the one that came out
                if (cfg_q.cbc) chain_q <= cfg_q.decrypt ? blk_q : core_result_i;
            end
            if (out_done) out_valid_q <= 1'b0;
        end
    end

    assign core_op_o     = {1'b0, cfg_q.decrypt};
    assign core_key_o    = key_q;
    assign core_data_o   = core_data_q;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_q;
    assign block_count_o = cnt_q;

endmodule

// File: tb/tb_aes128_block_ctrl.sv
// Bench for aes128_block_ctrl: table-driven core model plus an output scoreboard.

module tb_aes128_block_ctrl;
    localparam int CNT_W = 4;
    localparam int LCORE = 4;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1E = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] X1  = PT1 ^ IV;
    localparam logic [127:0] X2  = PT2 ^ CT1;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             cfg_cbc_i = 1'b0, cfg_decrypt_i = 1'b0;
    logic [127:0]     key_i = '0, iv_i = '0, in_data_i = '0;
    logic             iv_load_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b1;
    logic             in_ready_o, out_valid_o, core_start_o, busy_o;
    logic [127:0]     out_data_o, core_key_o, core_data_o;
    logic [1:0]       core_op_o;
    logic [127:0]     core_result_i = '0;
    logic             core_valid_i = 1'b0, core_ready_i = 1'b1;
    logic [CNT_W-1:0] block_count_o;

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;
    logic [127:0] exp_q[$];

    aes128_block_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_cbc_i(cfg_cbc_i), .cfg_decrypt_i(cfg_decrypt_i),
        .key_i(key_i), .iv_i(iv_i), .iv_load_i(iv_load_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .in_data_i(in_data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .core_start_o(core_start_o),
        .core_op_o(core_op_o), .core_key_o(core_key_o), .core_data_o(core_data_o),
        .core_result_i(core_result_i), .core_valid_i(core_valid_i), .core_ready_i(core_ready_i),
        .busy_o(busy_o), .block_count_o(block_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Known AES vectors by table; anything else goes through an invertible stand-in cipher.
    function automatic logic [127:0] core_fn(input logic [1:0] op, input logic [127:0] k,
                                             input logic [127:0] d);
        logic [127:0] t;
        if (op == 2'b00) begin
            if (k == K1 && d == P1) return C1E;
            if (k == K2 && d == X1) return CT1;
            if (k == K2 && d == X2) return CT2;
            return {d[119:0], d[127:120]} ^ k;
        end
        if (k == K1 && d == C1E) return P1;
        if (k == K2 && d == CT1) return X1;
        if (k == K2 && d == CT2) return X2;
        t = d ^ k;
        return {t[7:0], t[127:8]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int   core_cnt = 0;
    logic core_busy = 1'b0;
    always @(posedge clk_i) begin
        if (rst_i) begin
            core_busy    <= 1'b0;
            core_valid_i <= 1'b0;
            core_ready_i <= 1'b1;
            core_cnt     <= 0;
        end else if (core_start_o) begin
            core_busy     <= 1'b1;
            core_valid_i  <= 1'b0;
            core_ready_i  <= 1'b0;
            core_cnt      <= LCORE - 1;
            core_result_i <= core_fn(core_op_o, core_key_o, core_data_o);
        end else if (core_busy) begin
            if (core_cnt == 1) begin
                core_busy    <= 1'b0;
                core_valid_i <= 1'b1;
                core_ready_i <= 1'b1;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    always @(negedge clk_i) begin
        logic [127:0] e;
        if (!rst_i && core_start_o) start_cnt++;
        if (!rst_i && out_valid_o && out_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_extra: got %h, no output expected", out_data_o);
            end else begin
                e = exp_q.pop_front();
                if (out_data_o !== e) $display("FAIL scoreboard: got %h, expected %h", out_data_o, e);
                else n_pass++;
            end
        end
    end

    task automatic send(input logic cbc, input logic dec, input logic [127:0] k, input logic [127:0] d);
        int n;
        n = 0;
        cfg_cbc_i = cbc; cfg_decrypt_i = dec; key_i = k; in_data_i = d; in_valid_i = 1'b1;
        @(negedge clk_i);
        while (!in_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!in_ready_o) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready_o=%b after %0d cycles, expected 1", in_ready_o, n);
        end
        @(posedge clk_i); #1;
        // scramble the inputs; the block in flight must not see them
        in_valid_i = 1'b0; cfg_cbc_i = ~cbc; cfg_decrypt_i = ~dec; key_i = ~k; in_data_i = ~d;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!out_valid_o) begin
            n_checks++;
            $display("FAIL wait_out_timeout: out_valid_o=%b after %0d cycles, expected 1", out_valid_o, n);
        end
    endtask

    task automatic finish_out();
        int n;
        wait_out(n);
        @(posedge clk_i); #1;
    endtask

    task automatic load_iv(input logic [127:0] v);
        iv_load_i = 1'b1; iv_i = v;
        @(posedge clk_i); #1;
        iv_load_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy_o); else n_pass++;
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid: got %b, expected 0", out_valid_o); else n_pass++;
        n_checks++; if (block_count_o !== '0) $display("FAIL reset_count: got %0d, expected 0", block_count_o); else n_pass++;
        n_checks++; if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready: got %b, expected 1", in_ready_o); else n_pass++;
        n_checks++; if (core_start_o !== 1'b0) $display("FAIL reset_start: got %b, expected 0", core_start_o); else n_pass++;
        n_checks++; if (out_data_o !== '0) $display("FAIL reset_out_data: got %h, expected 0", out_data_o); else n_pass++;
        n_checks++; if ({core_op_o, core_key_o, core_data_o} !== '0)
            $display("FAIL reset_core_pins: got op %b key %h data %h, expected all 0", core_op_o, core_key_o, core_data_o);
        else n_pass++;
    endtask

    task automatic test_ecb();
        int s0, lat;
        s0 = start_cnt;
        send(1'b0, 1'b0, K1, P1);
        exp_q.push_back(C1E);
        n_checks++; if (core_start_o !== 1'b1) $display("FAIL ecb_start: got %b, expected 1", core_start_o); else n_pass++;
        n_checks++; if (core_op_o !== 2'b00) $display("FAIL ecb_op: got %b, expected 00", core_op_o); else n_pass++;
        n_checks++; if (core_key_o !== K1) $display("FAIL ecb_key: got %h, expected %h", core_key_o, K1); else n_pass++;
        n_checks++; if (core_data_o !== P1) $display("FAIL ecb_core_data: got %h, expected %h", core_data_o, P1); else n_pass++;
        wait_out(lat);
        n_checks++; if (lat != LCORE + 1) $display("FAIL ecb_latency: got %0d, expected %0d", lat, LCORE + 1); else n_pass++;
        @(posedge clk_i); #1;
        n_checks++; if (start_cnt - s0 != 1) $display("FAIL ecb_start_width: got %0d cycles, expected 1", start_cnt - s0); else n_pass++;
        n_checks++; if (block_count_o !== CNT_W'(1)) $display("FAIL ecb_count: got %0d, expected 1", block_count_o); else n_pass++;
    endtask

    task automatic test_cbc_enc();
        load_iv(IV);
        n_checks++; if (block_count_o !== '0) $display("FAIL cbc_enc_count_clear: got %0d, expected 0", block_count_o); else n_pass++;
        send(1'b1, 1'b0, K2, PT1);
        exp_q.push_back(CT1);
        n_checks++; if (core_data_o !== X1) $display("FAIL cbc_enc_xor1: got %h, expected %h", core_data_o, X1); else n_pass++;
        finish_out();
        send(1'b1, 1'b0, K2, PT2);
        exp_q.push_back(CT2);
        n_checks++; if (core_data_o !== X2) $display("FAIL cbc_enc_xor2: got %h, expected %h", core_data_o, X2); else n_pass++;
        finish_out();
        n_checks++; if (block_count_o !== CNT_W'(2)) $display("FAIL cbc_enc_count: got %0d, expected 2", block_count_o); else n_pass++;
    endtask

    task automatic test_cbc_dec();
        load_iv(IV);
        send(1'b1, 1'b1, K2, CT1);
        exp_q.push_back(PT1);
        n_checks++; if (core_op_o !== 2'b01) $display("FAIL cbc_dec_op: got %b, expected 01", core_op_o); else n_pass++;
        n_checks++; if (core_data_o !== CT1) $display("FAIL cbc_dec_core_data: got %h, expected %h", core_data_o, CT1); else n_pass++;
        finish_out();
        send(1'b1, 1'b1, K2, CT2);
        exp_q.push_back(PT2);
        finish_out();
        n_checks++; if (block_count_o !== CNT_W'(2)) $display("FAIL cbc_dec_count: got %0d, expected 2", block_count_o); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [127:0] d, held;
        logic stable;
        int n;
        d = rand128();
        out_ready_i = 1'b0;
        send(1'b0, 1'b0, K1, d);
        exp_q.push_back(core_fn(2'b00, K1, d));
        wait_out(n);
        held = out_data_o;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            if (!out_valid_o || out_data_o !== held || in_ready_o) stable = 1'b0;
        end
        n_checks++; if (!stable) $display("FAIL backpressure_hold: out_valid/out_data/in_ready changed, got stable=%b expected 1", stable); else n_pass++;
        @(posedge clk_i); #1 out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        n_checks++; if (busy_o !== 1'b0 || in_ready_o !== 1'b1)
            $display("FAIL backpressure_release: got busy %b in_ready %b, expected 0 1", busy_o, in_ready_o);
        else n_pass++;
        n_checks++; if (out_valid_o !== 1'b0 || out_data_o !== held)
            $display("FAIL backpressure_after: got valid %b data %h, expected 0 %h", out_valid_o, out_data_o, held);
        else n_pass++;
    endtask

    task automatic test_priority();
        logic [127:0] v, d, k, d2, r;
        v = rand128(); d = rand128(); k = rand128(); d2 = rand128();
        iv_load_i = 1'b1; iv_i = v;
        cfg_cbc_i = 1'b1; cfg_decrypt_i = 1'b0; key_i = k; in_data_i = d; in_valid_i = 1'b1;
        @(negedge clk_i);
        n_checks++; if (in_ready_o !== 1'b0) $display("FAIL prio_in_ready: got %b, expected 0", in_ready_o); else n_pass++;
        @(posedge clk_i); #1;
        n_checks++; if (busy_o !== 1'b0 || block_count_o !== '0)
            $display("FAIL prio_no_accept: got busy %b count %0d, expected 0 0", busy_o, block_count_o);
        else n_pass++;
        iv_load_i = 1'b0;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        n_checks++; if (busy_o !== 1'b1 || core_data_o !== (d ^ v))
            $display("FAIL prio_accept: got busy %b data %h, expected 1 %h", busy_o, core_data_o, d ^ v);
        else n_pass++;
        r = core_fn(2'b00, k, d ^ v);
        exp_q.push_back(r);
        // iv_load while busy must be ignored
        iv_load_i = 1'b1; iv_i = rand128();
        @(posedge clk_i); #1;
        iv_load_i = 1'b0;
        finish_out();
        n_checks++; if (block_count_o !== CNT_W'(1)) $display("FAIL prio_busy_ivload_count: got %0d, expected 1", block_count_o); else n_pass++;
        send(1'b1, 1'b0, k, d2);
        exp_q.push_back(core_fn(2'b00, k, d2 ^ r));
        n_checks++; if (core_data_o !== (d2 ^ r)) $display("FAIL prio_busy_ivload_chain: got %h, expected %h", core_data_o, d2 ^ r); else n_pass++;
        finish_out();
    endtask

    task automatic test_back_to_back();
        logic [127:0] chain, k, d, e;
        logic cbc, dec;
        logic gap_ok;
        chain = rand128();
        load_iv(chain);
        gap_ok = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cbc = (i < 8) ? 1'($urandom) : 1'b0;
            dec = 1'($urandom);
            k = rand128(); d = rand128();
            if (!cbc) e = core_fn({1'b0, dec}, k, d);
            else if (!dec) begin e = core_fn(2'b00, k, d ^ chain); chain = e; end
            else begin e = core_fn(2'b01, k, d) ^ chain; chain = d; end
            exp_q.push_back(e);
            if (i > 0 && in_ready_o !== 1'b1) gap_ok = 1'b0;
            send(cbc, dec, k, d);
            finish_out();
            if (i == 7) begin
                n_checks++; if (block_count_o !== CNT_W'(8)) $display("FAIL b2b_count8: got %0d, expected 8", block_count_o); else n_pass++;
            end
        end
        n_checks++; if (!gap_ok) $display("FAIL b2b_ready_after_handshake: got %b, expected 1", gap_ok); else n_pass++;
        n_checks++; if (block_count_o !== CNT_W'(1)) $display("FAIL b2b_count_wrap: got %0d, expected 1", block_count_o); else n_pass++;
    endtask

    task automatic test_reset_wait();
        logic [127:0] d;
        logic seen;
        send(1'b0, 1'b0, K1, P1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0)
            $display("FAIL rstwait_state: got busy %b valid %b, expected 0 0", busy_o, out_valid_o);
        else n_pass++;
        n_checks++; if (block_count_o !== '0 || out_data_o !== '0)
            $display("FAIL rstwait_regs: got count %0d data %h, expected 0 0", block_count_o, out_data_o);
        else n_pass++;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk_i);
            if (out_valid_o) seen = 1'b1;
        end
        n_checks++; if (seen) $display("FAIL rstwait_no_output: got out_valid %b, expected 0", seen); else n_pass++;
        @(posedge clk_i); #1;
        d = rand128();
        send(1'b1, 1'b0, K2, d);
        exp_q.push_back(core_fn(2'b00, K2, d));
        n_checks++; if (core_data_o !== d) $display("FAIL rstwait_chain_zero: got %h, expected %h", core_data_o, d); else n_pass++;
        finish_out();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ecb();
        test_cbc_enc();
        test_cbc_dec();
        test_backpressure();
        test_priority();
        test_back_to_back();
        test_reset_wait();
        repeat (3) @(posedge clk_i);
        n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
